// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM: shared edge/center-aligned counter, N_CH compare channels,
// shadowed period/duty/mode applied only at a period boundary.
module pwm_multi_gen #(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 16,
  parameter int RST_PERIOD = 100
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_update,
  input  logic [CNT_W-1:0]      cfg_period,
  input  logic [N_CH*CNT_W-1:0] cfg_duty,
  input  logic                  cfg_center,
  input  logic [N_CH-1:0]       ch_en,
  output logic [N_CH-1:0]       pwm_out,
  output logic                  period_start,
  output logic                  upd_pending,
  output logic                  upd_done
);

  localparam logic [CNT_W-1:0] P_RST = CNT_W'(RST_PERIOD);

  logic [CNT_W-1:0]      cnt, cnt_n, p_last;
  logic                  dir, dir_n;
  logic [CNT_W-1:0]      act_p, sh_p;
  logic [N_CH*CNT_W-1:0] act_d, sh_d;
  logic                  act_c, sh_c;
  logic                  bnd;
  logic [N_CH-1:0]       raw;

  // p_last wraps for P==0, but bnd is forced in that case
  always_comb begin
    p_last = act_p - 1'b1;
    bnd    = (act_p == '0)
           | (!act_c && cnt == p_last)
           | (act_c && dir && cnt == '0);
  end

  always_comb begin
    cnt_n = cnt;
    dir_n = dir;
    if (bnd) begin
      cnt_n = '0;
      dir_n = 1'b0;
    end else if (!act_c) begin
      cnt_n = cnt + 1'b1;
    end else if (!dir) begin
      if (cnt == p_last) dir_n = 1'b1;
      else cnt_n = cnt + 1'b1;
    end else begin
      cnt_n = cnt - 1'b1;
    end
  end

  always_comb begin
    raw = '0;
    for (int i = 0; i < N_CH; i++) begin
      raw[i] = ch_en[i] && (act_p != '0)
            && (cnt < act_d[i*CNT_W +: CNT_W]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt          <= '0;
      dir          <= 1'b0;
      act_p        <= P_RST;
      act_d        <= '0;
      act_c        <= 1'b0;
      sh_p         <= P_RST;
      sh_d         <= '0;
      sh_c         <= 1'b0;
      upd_pending  <= 1'b0;
      upd_done     <= 1'b0;
      pwm_out      <= '0;
      period_start <= 1'b0;
    end else begin
      cnt          <= cnt_n;
      dir          <= dir_n;
      pwm_out      <= raw;
      period_start <= (act_p != '0) && (cnt == '0) && !dir;
      upd_done     <= 1'b0;
      // a strobe landing on the boundary bypasses the shadow
      if (bnd && cfg_update) begin
        act_p       <= cfg_period;
        act_d       <= cfg_duty;
        act_c       <= cfg_center;
        sh_p        <= cfg_period;
        sh_d        <= cfg_duty;
        sh_c        <= cfg_center;
        upd_pending <= 1'b0;
        upd_done    <= 1'b1;
      end else if (bnd && upd_pending) begin
        act_p       <= sh_p;
        act_d       <= sh_d;
        act_c       <= sh_c;
        upd_pending <= 1'b0;
        upd_done    <= 1'b1;
      end else if (cfg_update) begin
        sh_p        <= cfg_period;
        sh_d        <= cfg_duty;
        sh_c        <= cfg_center;
        upd_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_multi_gen.sv
// Scoreboard bench for pwm_multi_gen: stimulus queues expected outputs,
// a negedge monitor pops and compares.
module tb_pwm_multi_gen;

  localparam int N  = 4;
  localparam int W  = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic           cfg_update;
  logic [W-1:0]   cfg_period;
  logic [N*W-1:0] cfg_duty;
  logic           cfg_center;
  logic [N-1:0]   ch_en;
  logic [N-1:0]   pwm_out;
  logic           period_start;
  logic           upd_pending;
  logic           upd_done;

  int n_chk  = 0;
  int n_fail = 0;
  string ph = "init";

  logic [6:0] q_exp[$];
  string      q_nm[$];

  always #5 clk = ~clk;

  pwm_multi_gen #(.N_CH(N), .CNT_W(W), .RST_PERIOD(100)) dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_update   (cfg_update),
    .cfg_period   (cfg_period),
    .cfg_duty     (cfg_duty),
    .cfg_center   (cfg_center),
    .ch_en        (ch_en),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .upd_pending  (upd_pending),
    .upd_done     (upd_done)
  );

  always @(negedge clk) begin
    if (q_exp.size() > 0) begin
      logic [6:0] e, a;
      string nm;
      e  = q_exp.pop_front();
      nm = q_nm.pop_front();
      a  = {pwm_out, period_start, upd_pending, upd_done};
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s @%0t: {pwm,ps,pend,done} got %b want %b",
                 nm, $time, a, e);
      end
    end
  end

  task automatic tk(input logic [3:0] p, input logic s,
                    input logic pe, input logic d);
    @(posedge clk);
    q_exp.push_back({p, s, pe, d});
    q_nm.push_back(ph);
    #1 cfg_update = 1'b0;
  endtask

  task automatic set_cfg(input int p, input int d0, input int d1,
                         input int d2, input logic c);
    cfg_update = 1'b1;
    cfg_period = W'(p);
    cfg_duty   = {16'd0, W'(d2), W'(d1), W'(d0)};
    cfg_center = c;
  endtask

  initial begin
    bit got;
    reset      = 1'b1;
    cfg_update = 1'b0;
    cfg_period = '0;
    cfg_duty   = '0;
    cfg_center = 1'b0;
    ch_en      = '0;

    ph = "reset";
    tk(4'b0, 0, 0, 0);
    tk(4'b0, 0, 0, 0);

    reset = 1'b0;
    ch_en = 4'b0001;
    set_cfg(10, 3, 0, 0, 0);
    got = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1 cfg_update = 1'b0;
      if (upd_done) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL sync: upd_done got 0 want 1 within 200 cycles");
    end

    ph = "edge_p10_d3";
    for (int k = 0; k < 20; k++)
      tk({3'b0, (k % 10) < 3}, (k % 10) == 0, 0, 0);

    ph = "shadow_d7";
    for (int c = 0; c < 4; c++) tk({3'b0, c < 3}, c == 0, 0, 0);
    set_cfg(10, 7, 0, 0, 0);
    for (int k = 0; k < 5; k++) tk(4'b0, 0, 1, 0);
    tk(4'b0, 0, 0, 1);
    for (int c = 0; c < 9; c++) tk({3'b0, c < 7}, c == 0, 0, 0);

    ph = "bnd_upd_p5";
    set_cfg(5, 2, 0, 0, 0);
    tk(4'b0, 0, 0, 1);
    for (int c = 0; c < 5; c++) tk({3'b0, c < 2}, c == 0, 0, 0);

    ph = "last_wins";
    tk(4'b0001, 1, 0, 0);
    set_cfg(5, 4, 0, 0, 0);
    tk(4'b0001, 0, 1, 0);
    set_cfg(5, 1, 0, 0, 0);
    tk(4'b0, 0, 1, 0);
    tk(4'b0, 0, 1, 0);
    tk(4'b0, 0, 0, 1);
    for (int c = 0; c < 4; c++) tk({3'b0, c < 1}, c == 0, 0, 0);

    ph = "duty_extremes";
    set_cfg(10, 0, 12, 5, 0);
    ch_en = 4'b0111;
    tk(4'b0, 0, 0, 1);
    tk(4'b0110, 1, 0, 0);
    tk(4'b0110, 0, 0, 0);
    ph = "ch_en_off";
    ch_en = 4'b0101;
    tk(4'b0100, 0, 0, 0);
    tk(4'b0100, 0, 0, 0);
    tk(4'b0100, 0, 0, 0);
    for (int k = 0; k < 4; k++) tk(4'b0, 0, 0, 0);

    ph = "center_p4";
    set_cfg(4, 1, 0, 0, 1);
    ch_en = 4'b0001;
    tk(4'b0, 0, 0, 1);
    for (int k = 0; k < 15; k++)
      tk({3'b0, (k % 8) == 0 || (k % 8) == 7}, (k % 8) == 0, 0, 0);

    ph = "p0";
    set_cfg(0, 3, 0, 0, 0);
    tk(4'b0001, 0, 0, 1);
    for (int k = 0; k < 5; k++) tk(4'b0, 0, 0, 0);

    ph = "p1";
    set_cfg(1, 1, 0, 0, 0);
    tk(4'b0, 0, 0, 1);
    for (int k = 0; k < 3; k++) tk(4'b0001, 1, 0, 0);

    ph = "reset_mid";
    set_cfg(10, 3, 0, 0, 0);
    tk(4'b0001, 1, 0, 1);
    tk(4'b0001, 1, 0, 0);
    tk(4'b0001, 0, 0, 0);
    set_cfg(10, 7, 0, 0, 0);
    tk(4'b0001, 0, 1, 0);
    tk(4'b0, 0, 1, 0);
    reset = 1'b1;
    tk(4'b0, 0, 0, 0);
    reset = 1'b0;
    tk(4'b0, 1, 0, 0);
    for (int k = 0; k < 13; k++) tk(4'b0, 0, 0, 0);

    @(negedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
